// File: rtl/cnn_acc_post_pkg.sv
// Shared CNN core widths and output-range constants for the post-accumulation stage.
// CNN_POST_RELU_EN selects unsigned ReLU output; otherwise output is signed.
package cnn_acc_post_pkg;

  localparam int unsigned CO     = 16;
  localparam int unsigned ACI_BW = 22;
  localparam int unsigned B_BW   = 16;
  localparam int unsigned O_F_BW = 8;
  localparam int unsigned SHIFT  = 6;
  localparam int unsigned SUM_BW = ACI_BW + 1;

  localparam int unsigned FMAP_BW = CO * O_F_BW;

`ifdef CNN_POST_RELU_EN
  localparam logic signed [SUM_BW-1:0] OUT_MAX = SUM_BW'((1 << O_F_BW) - 1);
`else
  localparam logic signed [SUM_BW-1:0] OUT_MAX = SUM_BW'((1 << (O_F_BW - 1)) - 1);
  localparam logic signed [SUM_BW-1:0] OUT_MIN = SUM_BW'(-(1 << (O_F_BW - 1)));
`endif

  typedef logic [CO-1:0][SUM_BW-1:0] sum_vec_t;
  typedef logic [FMAP_BW-1:0]        fmap_t;

endpackage

// File: rtl/cnn_post_fifo.sv
// Show-ahead synchronous FIFO; head data reads as zero while empty.
// Depth must be a power of two. Independent of CNN_POST_RELU_EN.
module cnn_post_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en_i);
    rd_ptr_d = rd_ptr_q + AW'(rd_en_i);
    count_d  = count_q + CW'(wr_en_i) - CW'(rd_en_i);
    full_d   = (count_d == CW'(DEPTH));
    empty_d  = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i && !clr_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  assign rd_data_o = empty_q ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;

endmodule

// File: rtl/cnn_acc_post.sv
// Post-accumulation stage: bias add, optional ReLU, arithmetic shift, saturate, output FIFO.
// Define CNN_POST_RELU_EN for unsigned ReLU output; default build produces signed output.
module cnn_acc_post
  import cnn_acc_post_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned FRAME_PIX  = 256
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_soft_reset,
  input  logic [CO*ACI_BW-1:0]          i_in_ci_acc,
  input  logic [CO*B_BW-1:0]            i_in_bias,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  output logic [CO*O_F_BW-1:0]          o_ot_fmap,
  output logic                          o_ot_valid,
  input  logic                          i_ot_ready,
  output logic                          o_frame_done,
  output logic [$clog2(FRAME_PIX)-1:0]  o_pix_cnt
);

  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CRW   = CW + 1;
  localparam int unsigned PIX_W = $clog2(FRAME_PIX);

  logic             clr;
  logic             accept;
  logic             emit;
  logic             s1_valid_q, s1_valid_d;
  sum_vec_t         sum_q, sum_d;
  fmap_t            px_d;
  logic             fifo_wr;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic             frame_done_q, frame_done_d;

  assign clr = reset | i_soft_reset;

  // Credits cover FIFO occupancy plus the beat in flight, so a write always finds room.
  assign o_in_ready = ({1'b0, fifo_count} + CRW'(s1_valid_q)) < CRW'(FIFO_DEPTH);
  assign accept     = i_in_valid & o_in_ready;
  assign o_ot_valid = ~fifo_empty;
  assign emit       = o_ot_valid & i_ot_ready;
  assign fifo_wr    = s1_valid_q & ~fifo_full;

  for (genvar k = 0; k < CO; k++) begin : g_ch
    logic signed [ACI_BW-1:0] acc;
    logic signed [B_BW-1:0]   bias;
    logic signed [SUM_BW-1:0] relu;
    logic signed [SUM_BW-1:0] shr;
    logic [O_F_BW-1:0]        px;

    assign acc  = i_in_ci_acc[ACI_BW*k +: ACI_BW];
    assign bias = i_in_bias[B_BW*k +: B_BW];
    assign sum_d[k] = {acc[ACI_BW-1], acc} + {{(SUM_BW-B_BW){bias[B_BW-1]}}, bias};

    always_comb begin
`ifdef CNN_POST_RELU_EN
      relu = sum_q[k][SUM_BW-1] ? '0 : $signed(sum_q[k]);
`else
      relu = $signed(sum_q[k]);
`endif
      shr = relu >>> SHIFT;
      if (shr > OUT_MAX) begin
        px = O_F_BW'(OUT_MAX);
`ifndef CNN_POST_RELU_EN
      end else if (shr < OUT_MIN) begin
        px = O_F_BW'(OUT_MIN);
`endif
      end else begin
        px = O_F_BW'(shr);
      end
    end

    assign px_d[O_F_BW*k +: O_F_BW] = px;
  end

  always_comb begin
    s1_valid_d = accept;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      sum_q <= sum_d;
    end
  end

  // Second stage registers directly into the FIFO storage.
  cnn_post_fifo #(
    .W     (FMAP_BW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .clr_i     (clr),
    .wr_en_i   (fifo_wr),
    .wr_data_i (px_d),
    .rd_en_i   (emit),
    .rd_data_o (o_ot_fmap),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    frame_done_d = 1'b0;
    if (emit) begin
      if (pix_cnt_q == PIX_W'(FRAME_PIX - 1)) begin
        pix_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + PIX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      pix_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pix_cnt_q    <= pix_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_pix_cnt    = pix_cnt_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_cnn_acc_post.sv
// Self-checking bench for cnn_acc_post with a scoreboard of expected output pixels.
// Expected values follow CNN_POST_RELU_EN the same way the design does.
module tb_cnn_acc_post;
  import cnn_acc_post_pkg::*;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FRAME_PIX  = 4;
  localparam int unsigned PIX_W      = $clog2(FRAME_PIX);

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 i_soft_reset;
  logic [CO*ACI_BW-1:0] i_in_ci_acc;
  logic [CO*B_BW-1:0]   i_in_bias;
  logic                 i_in_valid;
  logic                 o_in_ready;
  logic [FMAP_BW-1:0]   o_ot_fmap;
  logic                 o_ot_valid;
  logic                 i_ot_ready;
  logic                 o_frame_done;
  logic [PIX_W-1:0]     o_pix_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int n_done = 0;
  bit mon_en = 1'b0;
  int exp_pix = 0;
  bit exp_done = 1'b0;
  logic [FMAP_BW-1:0] sb [$];

  always #5 clk = ~clk;

  cnn_acc_post #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FRAME_PIX  (FRAME_PIX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_soft_reset (i_soft_reset),
    .i_in_ci_acc  (i_in_ci_acc),
    .i_in_bias    (i_in_bias),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .o_ot_fmap    (o_ot_fmap),
    .o_ot_valid   (o_ot_valid),
    .i_ot_ready   (i_ot_ready),
    .o_frame_done (o_frame_done),
    .o_pix_cnt    (o_pix_cnt)
  );

  task automatic chk(input string tag, input logic [FMAP_BW-1:0] obs, input logic [FMAP_BW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [O_F_BW-1:0] exp_px(input int a, input int b);
    int s;
    s = a + b;
`ifdef CNN_POST_RELU_EN
    if (s < 0) s = 0;
    s = s >>> SHIFT;
    if (s > (1 << O_F_BW) - 1) s = (1 << O_F_BW) - 1;
`else
    s = s >>> SHIFT;
    if (s > (1 << (O_F_BW - 1)) - 1) s = (1 << (O_F_BW - 1)) - 1;
    if (s < -(1 << (O_F_BW - 1))) s = -(1 << (O_F_BW - 1));
`endif
    return O_F_BW'(s);
  endfunction

  function automatic logic [FMAP_BW-1:0] exp_vec(input logic [CO*ACI_BW-1:0] acc,
                                                 input logic [CO*B_BW-1:0] bias);
    logic [FMAP_BW-1:0]       v;
    logic signed [ACI_BW-1:0] a;
    logic signed [B_BW-1:0]   b;
    v = '0;
    for (int k = 0; k < CO; k++) begin
      a = acc[ACI_BW*k +: ACI_BW];
      b = bias[B_BW*k +: B_BW];
      v[O_F_BW*k +: O_F_BW] = exp_px(int'(a), int'(b));
    end
    return v;
  endfunction

  // Scoreboard and pixel-counter model, evaluated mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pix_cnt", FMAP_BW'(o_pix_cnt), FMAP_BW'(exp_pix));
      chk("frame_done", FMAP_BW'(o_frame_done), FMAP_BW'(exp_done));
    end
    if (o_frame_done === 1'b1) n_done++;
    if (reset || i_soft_reset) begin
      exp_pix  = 0;
      exp_done = 1'b0;
      sb.delete();
    end else begin
      exp_done = 1'b0;
      if (o_ot_valid && i_ot_ready) begin
        chk("emit_expected", FMAP_BW'(sb.size() > 0), FMAP_BW'(1));
        if (sb.size() > 0) chk("fmap_order", o_ot_fmap, sb.pop_front());
        exp_done = (exp_pix == int'(FRAME_PIX) - 1);
        exp_pix  = exp_done ? 0 : exp_pix + 1;
      end
      if (i_in_valid && o_in_ready) sb.push_back(exp_vec(i_in_ci_acc, i_in_bias));
    end
  end

  task automatic set_all(input int a, input int b);
    for (int k = 0; k < CO; k++) begin
      i_in_ci_acc[ACI_BW*k +: ACI_BW] = ACI_BW'(a);
      i_in_bias[B_BW*k +: B_BW]       = B_BW'(b);
    end
  endtask

  task automatic rand_beat();
    for (int k = 0; k < CO; k++) begin
      i_in_ci_acc[ACI_BW*k +: ACI_BW] = ACI_BW'(int'($urandom_range(40000, 0)) - 20000);
      i_in_bias[B_BW*k +: B_BW]       = B_BW'(int'($urandom_range(2000, 0)) - 1000);
    end
  endtask

  task automatic one_beat(input string tag, input int a, input int b, input logic [O_F_BW-1:0] e);
    logic [FMAP_BW-1:0] ev;
    ev = {CO{e}};
    set_all(a, b);
    i_in_valid = 1'b1;
    chk({tag, "_in_ready"}, FMAP_BW'(o_in_ready), FMAP_BW'(1));
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    chk({tag, "_lat1"}, FMAP_BW'(o_ot_valid), FMAP_BW'(0));
    @(posedge clk); #1;
    chk({tag, "_lat2"}, FMAP_BW'(o_ot_valid), FMAP_BW'(1));
    chk({tag, "_fmap"}, o_ot_fmap, ev);
    @(posedge clk); #1;
  endtask

  task automatic stream(input int n, input int max_cyc, input bit rnd_rdy,
                        output int got, output int cyc);
    bit fired;
    got = 0;
    cyc = 0;
    rand_beat();
    i_in_valid = 1'b1;
    while (got < n && cyc < max_cyc) begin
      @(negedge clk);
      fired = o_in_ready;
      @(posedge clk); #1;
      cyc++;
      if (fired) begin
        got++;
        rand_beat();
      end
      if (rnd_rdy) i_ot_ready = 1'($urandom_range(1, 0));
    end
    i_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int c;
    c = 0;
    i_ot_ready = 1'b1;
    while ((sb.size() != 0 || o_ot_valid) && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    chk({tag, "_drained"}, FMAP_BW'(sb.size()), FMAP_BW'(0));
    chk({tag, "_ready_back"}, FMAP_BW'(o_in_ready), FMAP_BW'(1));
  endtask

  initial begin
    int got;
    int cyc;
    reset        = 1'b1;
    i_soft_reset = 1'b0;
    i_in_valid   = 1'b0;
    i_ot_ready   = 1'b1;
    i_in_ci_acc  = '0;
    i_in_bias    = '0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    chk("rst_ot_valid", FMAP_BW'(o_ot_valid), FMAP_BW'(0));
    chk("rst_frame_done", FMAP_BW'(o_frame_done), FMAP_BW'(0));
    chk("rst_fmap", o_ot_fmap, FMAP_BW'(0));
    chk("rst_in_ready", FMAP_BW'(o_in_ready), FMAP_BW'(1));
    chk("rst_pix_cnt", FMAP_BW'(o_pix_cnt), FMAP_BW'(0));

    one_beat("basic", 1000, 24, 8'd16);
`ifdef CNN_POST_RELU_EN
    one_beat("neg", -500, 100, 8'h00);
    one_beat("sat_hi", 20000, 0, 8'hFF);
    one_beat("sat_lo", -20000, 0, 8'h00);
`else
    one_beat("neg", -500, 100, 8'hF9);
    one_beat("sat_hi", 20000, 0, 8'h7F);
    one_beat("sat_lo", -20000, 0, 8'h80);
`endif

    stream(12, 100, 1'b0, got, cyc);
    chk("stream_accepts", FMAP_BW'(got), FMAP_BW'(12));
    chk("stream_no_bubble", FMAP_BW'(cyc), FMAP_BW'(12));
    wait_drain("stream");

    stream(30, 400, 1'b1, got, cyc);
    chk("rnd_accepts", FMAP_BW'(got), FMAP_BW'(30));
    wait_drain("rnd");

    i_ot_ready = 1'b0;
    stream(8, 10, 1'b0, got, cyc);
    chk("bp_accepts", FMAP_BW'(got), FMAP_BW'(FIFO_DEPTH));
    chk("bp_in_ready", FMAP_BW'(o_in_ready), FMAP_BW'(0));
    chk("bp_ot_valid", FMAP_BW'(o_ot_valid), FMAP_BW'(1));
    wait_drain("bp");

    i_soft_reset = 1'b1;
    @(posedge clk); #1;
    i_soft_reset = 1'b0;
    n_done = 0;
    stream(9, 50, 1'b0, got, cyc);
    chk("frame_accepts", FMAP_BW'(got), FMAP_BW'(9));
    wait_drain("frame");
    repeat (2) @(posedge clk);
    #1;
    chk("frame_pulses", FMAP_BW'(n_done), FMAP_BW'(2));
    chk("frame_pix_cnt", FMAP_BW'(o_pix_cnt), FMAP_BW'(1));

    i_ot_ready = 1'b0;
    stream(3, 10, 1'b0, got, cyc);
    chk("sr_accepts", FMAP_BW'(got), FMAP_BW'(3));
    chk("sr_pre_valid", FMAP_BW'(o_ot_valid), FMAP_BW'(1));
    i_soft_reset = 1'b1;
    i_in_valid   = 1'b1;
    i_ot_ready   = 1'b1;
    rand_beat();
    @(posedge clk); #1;
    i_soft_reset = 1'b0;
    i_in_valid   = 1'b0;
    chk("sr_ot_valid", FMAP_BW'(o_ot_valid), FMAP_BW'(0));
    chk("sr_pix_cnt", FMAP_BW'(o_pix_cnt), FMAP_BW'(0));
    chk("sr_in_ready", FMAP_BW'(o_in_ready), FMAP_BW'(1));
    chk("sr_fmap", o_ot_fmap, FMAP_BW'(0));
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("sr_no_stale", FMAP_BW'(o_ot_valid), FMAP_BW'(0));
    end

    stream(10, 200, 1'b1, got, cyc);
    chk("post_sr_accepts", FMAP_BW'(got), FMAP_BW'(10));
    wait_drain("post_sr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
